// File: rtl/float_adder_if.sv
// Request/acknowledge bus between the product source and the float adder.
// The master drives operands and start_sig; the adder returns result, done_sig and busy.
interface float_adder_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        sub;
    logic        start_sig;
    logic [31:0] result;
    logic        done_sig;
    logic        busy;

    modport master (output A, B, sub, start_sig, input result, done_sig, busy);
    modport slave  (input A, B, sub, start_sig, output result, done_sig, busy);
endinterface

// File: rtl/float_adder.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor, one operation in flight, fixed latency.
// Define FLOAT_ADDER_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module float_adder #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    float_adder_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int XW = MW + 3;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] DIFF_MAX = EXP_W'(XW - 1);
    localparam logic [EW-1:0]    EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        ST_IDLE, ST_UNPACK, ST_ALIGN, ST_ADD, ST_NORM, ST_ROUND, ST_DONE, ST_WAIT_LOW
    } state_t;

    function automatic logic [4:0] lzc(input logic [XW-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'(XW);
        found = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(XW - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    state_t            state_r;
    logic [W-1:0]      a_r, b_r, result_r, res_r, spec_val_r;
    logic              sub_r, done_r, busy_r, spec_r;
    logic              sa_r, sb_r, sign_big_r, diff_r, zero_r, sign_r;
    logic [EXP_W-1:0]  ea_r, eb_r, exp_big_r;
    logic [MW-1:0]     ma_r, mb_r;
    logic [XW-1:0]     man_big_r, man_small_r, norm_man_r;
    logic [XW:0]       sum_r;
    logic signed [EW-1:0] norm_exp_r;

    logic [EXP_W-1:0]  ea_s, eb_s, exp_big_s, exp_small_s, diff_s;
    logic [MAN_W-1:0]  fa_s, fb_s;
    logic [MW-1:0]     ma_s, mb_s, man_big_s, man_small_s, man_f_s;
    logic              sb_eff_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, spec_s, a_big_s;
    logic              sign_big_s, sign_small_s, lost_s, zero_s, inc_s;
    logic [W-1:0]      spec_val_s, res_s;
    logic [XW-1:0]     small_ext_s, shifted_s, small_sh_s, norm_man_s;
    logic [XW:0]       sum_s;
    logic [4:0]        lz_s;
    logic [MW:0]       rnd_s;
    logic signed [EW-1:0] exp_base_s, norm_exp_s, exp_f_s;

    assign bus.result   = result_r;
    assign bus.done_sig = done_r;
    assign bus.busy     = busy_r;

    // Unpack: field split, denormal flush and special-operand classification
    always_comb begin
        ea_s     = a_r[W-2 -: EXP_W];
        eb_s     = b_r[W-2 -: EXP_W];
        fa_s     = a_r[MAN_W-1:0];
        fb_s     = b_r[MAN_W-1:0];
        sb_eff_s = b_r[W-1] ^ sub_r;
        a_nan_s  = (ea_s == EXP_ONES) && (fa_s != {MAN_W{1'b0}});
        b_nan_s  = (eb_s == EXP_ONES) && (fb_s != {MAN_W{1'b0}});
        a_inf_s  = (ea_s == EXP_ONES) && (fa_s == {MAN_W{1'b0}});
        b_inf_s  = (eb_s == EXP_ONES) && (fb_s == {MAN_W{1'b0}});
        ma_s     = (ea_s == EXP_ZERO) ? {MW{1'b0}} : {1'b1, fa_s};
        mb_s     = (eb_s == EXP_ZERO) ? {MW{1'b0}} : {1'b1, fb_s};
        spec_s     = 1'b1;
        spec_val_s = QNAN;
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_r[W-1] != sb_eff_s))) begin
            spec_val_s = QNAN;
        end else if (a_inf_s) begin
            spec_val_s = {a_r[W-1], EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf_s) begin
            spec_val_s = {sb_eff_s, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_s     = 1'b0;
            spec_val_s = {W{1'b0}};
        end
    end

    // Align: order by magnitude, then shift the small mantissa with sticky collection
    always_comb begin
        a_big_s = {ea_r, ma_r} >= {eb_r, mb_r};
        if (a_big_s) begin
            exp_big_s = ea_r; man_big_s = ma_r; sign_big_s = sa_r;
            exp_small_s = eb_r; man_small_s = mb_r; sign_small_s = sb_r;
        end else begin
            exp_big_s = eb_r; man_big_s = mb_r; sign_big_s = sb_r;
            exp_small_s = ea_r; man_small_s = ma_r; sign_small_s = sa_r;
        end
        diff_s      = exp_big_s - exp_small_s;
        small_ext_s = {man_small_s, 3'b000};
        shifted_s   = small_ext_s >> diff_s;
        lost_s      = |(small_ext_s & ~({XW{1'b1}} << diff_s));
        if (diff_s >= DIFF_MAX) begin
            small_sh_s = {{(XW-1){1'b0}}, |man_small_s};
        end else begin
            small_sh_s = {shifted_s[XW-1:1], shifted_s[0] | lost_s};
        end
    end

    // Add/subtract magnitudes; the big operand always dominates so no negative result
    always_comb begin
        if (diff_r) begin
            sum_s = {1'b0, man_big_r} - {1'b0, man_small_r};
        end else begin
            sum_s = {1'b0, man_big_r} + {1'b0, man_small_r};
        end
    end

    // Normalise: carry shifts right keeping sticky, otherwise left by leading-zero count
    always_comb begin
        lz_s       = lzc(sum_r[XW-1:0]);
        exp_base_s = {2'b00, exp_big_r};
        zero_s     = 1'b0;
        if (sum_r[XW]) begin
            norm_man_s = {sum_r[XW:2], sum_r[1] | sum_r[0]};
            norm_exp_s = exp_base_s + EXP_ONE;
        end else if (sum_r[XW-1:0] == {XW{1'b0}}) begin
            norm_man_s = {XW{1'b0}};
            norm_exp_s = {EW{1'b0}};
            zero_s     = 1'b1;
        end else begin
            norm_man_s = sum_r[XW-1:0] << lz_s;
            norm_exp_s = exp_base_s - {{(EW-5){1'b0}}, lz_s};
        end
    end

    // Round, renormalise on mantissa overflow and clamp to Inf or zero
    always_comb begin
`ifdef FLOAT_ADDER_ROUND_NEAREST_EN
        inc_s = norm_man_r[2] & (norm_man_r[1] | norm_man_r[0] | norm_man_r[3]);
`else
        inc_s = 1'b0;
`endif
        rnd_s = {1'b0, norm_man_r[XW-1:3]} + {{MW{1'b0}}, inc_s};
        if (rnd_s[MW]) begin
            man_f_s = rnd_s[MW:1];
            exp_f_s = norm_exp_r + EXP_ONE;
        end else begin
            man_f_s = rnd_s[MW-1:0];
            exp_f_s = norm_exp_r;
        end
        if (spec_r) begin
            res_s = spec_val_r;
        end else if (zero_r || (exp_f_s <= $signed({EW{1'b0}}))) begin
            res_s = {sign_r, {(W-1){1'b0}}};
        end else if (exp_f_s >= $signed({2'b00, EXP_ONES})) begin
            res_s = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            res_s = {sign_r, exp_f_s[EXP_W-1:0], man_f_s[MAN_W-1:0]};
        end
    end

    // Control FSM and stage registers; each stage register updates only in its own state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r <= {W{1'b0}}; b_r <= {W{1'b0}}; sub_r <= 1'b0;
            sa_r <= 1'b0; sb_r <= 1'b0; ea_r <= EXP_ZERO; eb_r <= EXP_ZERO;
            ma_r <= {MW{1'b0}}; mb_r <= {MW{1'b0}};
            spec_r <= 1'b0; spec_val_r <= {W{1'b0}};
            sign_big_r <= 1'b0; diff_r <= 1'b0; exp_big_r <= EXP_ZERO;
            man_big_r <= {XW{1'b0}}; man_small_r <= {XW{1'b0}};
            sum_r <= {(XW+1){1'b0}};
            norm_man_r <= {XW{1'b0}}; norm_exp_r <= {EW{1'b0}};
            zero_r <= 1'b0; sign_r <= 1'b0;
            res_r <= {W{1'b0}}; result_r <= {W{1'b0}};
            done_r <= 1'b0; busy_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_sig) begin
                        a_r     <= bus.A;
                        b_r     <= bus.B;
                        sub_r   <= bus.sub;
                        busy_r  <= 1'b1;
                        state_r <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    sa_r <= a_r[W-1]; sb_r <= sb_eff_s;
                    ea_r <= (ma_s == {MW{1'b0}}) ? EXP_ZERO : ea_s;
                    eb_r <= (mb_s == {MW{1'b0}}) ? EXP_ZERO : eb_s;
                    ma_r <= ma_s; mb_r <= mb_s;
                    spec_r <= spec_s; spec_val_r <= spec_val_s;
                    state_r <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    sign_big_r  <= sign_big_s;
                    diff_r      <= sign_big_s ^ sign_small_s;
                    exp_big_r   <= exp_big_s;
                    man_big_r   <= {man_big_s, 3'b000};
                    man_small_r <= small_sh_s;
                    state_r     <= ST_ADD;
                end
                ST_ADD: begin
                    sum_r   <= sum_s;
                    state_r <= ST_NORM;
                end
                ST_NORM: begin
                    norm_man_r <= norm_man_s;
                    norm_exp_r <= norm_exp_s;
                    zero_r     <= zero_s;
                    // An exact cancellation of opposite signs is +0
                    sign_r     <= (zero_s && diff_r) ? 1'b0 : sign_big_r;
                    state_r    <= ST_ROUND;
                end
                ST_ROUND: begin
                    res_r   <= res_s;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    result_r <= res_r;
                    done_r   <= 1'b1;
                    state_r  <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!bus.start_sig) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_float_adder.sv
// Scoreboard bench for float_adder: stimulus pushes expected sums, a monitor pops them on done_sig.
// The reference model adds exactly in a wide fixed-point integer and then rounds once.
module tb_float_adder;
    logic clk;
    logic rst_n;
    float_adder_if ifc ();

    float_adder dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

`ifdef FLOAT_ADDER_ROUND_NEAREST_EN
    localparam logic [31:0] RND_EXP = 32'h3F800001;
`else
    localparam logic [31:0] RND_EXP = 32'h3F800000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Exact value = mag * 2^-149 with mag a wide integer; round once from the exact sum.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [7:0]   ea, eb;
        logic [22:0]  fa, fb;
        logic         sa, sb, sr, inc;
        logic [299:0] ma, mb, mag;
        logic [23:0]  man;
        int           p, e;
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        sa = a[31]; sb = b[31] ^ s;
        if ((ea == 8'hFF && fa != 23'h0) || (eb == 8'hFF && fb != 23'h0)) return 32'h7FC00000;
        if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
        if (ea == 8'hFF) return {sa, 8'hFF, 23'h0};
        if (eb == 8'hFF) return {sb, 8'hFF, 23'h0};
        ma = (ea == 8'h0) ? 300'h0 : (300'({1'b1, fa}) << (ea - 8'd1));
        mb = (eb == 8'h0) ? 300'h0 : (300'({1'b1, fb}) << (eb - 8'd1));
        if (sa == sb) begin
            mag = ma + mb; sr = sa;
            if (mag == 300'h0) return {sa, 31'h0};
        end else if (ma >= mb) begin
            mag = ma - mb; sr = sa;
        end else begin
            mag = mb - ma; sr = sb;
        end
        if (mag == 300'h0) return 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        inc = 1'b0;
        if (p >= 23) begin
            man = 24'(mag >> (p - 23));
`ifdef FLOAT_ADDER_ROUND_NEAREST_EN
            if (p >= 24)
                inc = mag[p-24] && (((mag & ((300'h1 << (p - 24)) - 300'h1)) != 300'h0) || man[0]);
`endif
        end else begin
            man = 24'(mag << (23 - p));
        end
        if (inc) begin
            if (man == 24'hFFFFFF) begin man = 24'h800000; e++; end
            else man = man + 24'h1;
        end
        if (e >= 255) return {sr, 8'hFF, 23'h0};
        if (e <= 0) return {sr, 31'h0};
        return {sr, 8'(e), man[22:0]};
    endfunction

    // Monitor: every done_sig pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && ifc.done_sig) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'h1, 32'h0);
            end else begin
                check("result", ifc.result, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int hold, input logic [31:0] req);
        int cycles;
        @(negedge clk);
        ifc.A = a; ifc.B = b; ifc.sub = s; ifc.start_sig = 1'b1;
        exp_q.push_back(req);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                ifc.A = $urandom; ifc.B = $urandom; ifc.sub = 1'($urandom_range(0, 1));
            end
        end while (!ifc.done_sig && cycles < 20);
        check("latency", 32'(cycles), 32'd7);
        check("busy_at_done", {31'h0, ifc.busy}, 32'h1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("held_no_done", {31'h0, ifc.done_sig}, 32'h0);
            check("held_busy", {31'h0, ifc.busy}, 32'h1);
        end
        ifc.start_sig = 1'b0;
        @(posedge clk); #1;
        check("busy_low", {31'h0, ifc.busy}, 32'h0);
    endtask

    function automatic logic [31:0] special_val(input int k);
        case (k)
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00000;
            5: return 32'h00012345;
            default: return 32'h7F7FFFFF;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic        s;
        rst_n = 1'b0;
        ifc.A = 32'h0; ifc.B = 32'h0; ifc.sub = 1'b0; ifc.start_sig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", ifc.result, 32'h0);
        check("rst_done", {31'h0, ifc.done_sig}, 32'h0);
        check("rst_busy", {31'h0, ifc.busy}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        run_op(32'h40200000, 32'h40A00000, 1'b0, 0, 32'h40F00000);
        run_op(32'h41480000, 32'h41480000, 1'b1, 0, 32'h00000000);
        run_op(32'h80000000, 32'h80000000, 1'b0, 0, 32'h80000000);
        run_op(32'h3F800000, 32'h33C00000, 1'b0, 0, RND_EXP);
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, 32'h7F800000);
        run_op(32'h7F800000, 32'hFF800000, 1'b0, 0, 32'h7FC00000);
        run_op(32'h7FC00000, 32'h3F800000, 1'b0, 0, 32'h7FC00000);
        run_op(32'h40A00000, 32'h40200000, 1'b1, 3, 32'h40200000);

        // Abort in ALIGN: outputs clear at once and the aborted op never completes
        @(negedge clk);
        ifc.A = 32'h3F800000; ifc.B = 32'h40000000; ifc.sub = 1'b0; ifc.start_sig = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_result", ifc.result, 32'h0);
        check("abort_done", {31'h0, ifc.done_sig}, 32'h0);
        check("abort_busy", {31'h0, ifc.busy}, 32'h0);
        ifc.start_sig = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_op(32'h3F800000, 32'h40000000, 1'b0, 0, 32'h40400000);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: ;
                1: b[30:23] = a[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
                2: b = a ^ 32'($urandom_range(0, 255));
                3: b = special_val(int'($urandom_range(0, 6)));
                default: begin
                    a[30:23] = 8'd254 - 8'($urandom_range(0, 2));
                    b[30:23] = 8'd254 - 8'($urandom_range(0, 2));
                end
            endcase
            run_op(a, b, s, int'($urandom_range(0, 2)), ref_add(a, b, s));
        end

        repeat (5) @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
